// File: rtl/simple_pipeline.sv
// simple_pipeline: 5-stage in-order MIPS integer-subset pipeline (IF/ID/EX/MEM/WB), no stalls.
// Optional macro SIMPLE_PIPELINE_FORWARDING_EN enables EX operand bypass from EX/MEM and MEM/WB.
module simple_pipeline (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction_in,
    output logic [31:0] result_out
);

    typedef enum logic [3:0] {
        ALU_NOP,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLTU,
        ALU_PASSB
    } alu_op_t;

    logic [31:0] r_regs [32];

    logic [31:0] r_ifid_instr;

    alu_op_t     r_idex_op;
    logic [31:0] r_idex_rs_val;
    logic [31:0] r_idex_rt_val;
    logic [31:0] r_idex_imm;
    logic        r_idex_use_imm;
    logic        r_idex_wen;
    logic [4:0]  r_idex_dst;
`ifdef SIMPLE_PIPELINE_FORWARDING_EN
    logic [4:0]  r_idex_rs;
    logic [4:0]  r_idex_rt;
`endif

    logic [31:0] r_exmem_result;
    logic        r_exmem_wen;
    logic [4:0]  r_exmem_dst;

    logic [31:0] r_memwb_result;
    logic        r_memwb_wen;
    logic [4:0]  r_memwb_dst;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm16;
    alu_op_t     w_op;
    logic [31:0] w_imm;
    logic        w_use_imm;
    logic [4:0]  w_dst;
    logic        w_wen;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_op_a;
    logic [31:0] w_rt_fwd;
    logic [31:0] w_op_b;
    logic [31:0] w_alu_result;

    assign w_opcode = r_ifid_instr[31:26];
    assign w_rs     = r_ifid_instr[25:21];
    assign w_rt     = r_ifid_instr[20:16];
    assign w_rd     = r_ifid_instr[15:11];
    assign w_funct  = r_ifid_instr[5:0];
    assign w_imm16  = r_ifid_instr[15:0];

    always_comb begin
        w_op      = ALU_NOP;
        w_imm     = 32'h0;
        w_use_imm = 1'b0;
        w_dst     = w_rd;
        if (w_opcode == 6'h00) begin
            case (w_funct)
                6'h21:   w_op = ALU_ADD;
                6'h23:   w_op = ALU_SUB;
                6'h24:   w_op = ALU_AND;
                6'h25:   w_op = ALU_OR;
                6'h26:   w_op = ALU_XOR;
                6'h2A:   w_op = ALU_SLT;
                6'h2B:   w_op = ALU_SLTU;
                default: w_op = ALU_NOP;
            endcase
        end else begin
            w_use_imm = 1'b1;
            w_dst     = w_rt;
            case (w_opcode)
                6'h09: begin w_op = ALU_ADD;   w_imm = {{16{w_imm16[15]}}, w_imm16}; end
                6'h0A: begin w_op = ALU_SLT;   w_imm = {{16{w_imm16[15]}}, w_imm16}; end
                6'h0C: begin w_op = ALU_AND;   w_imm = {16'h0, w_imm16}; end
                6'h0D: begin w_op = ALU_OR;    w_imm = {16'h0, w_imm16}; end
                6'h0E: begin w_op = ALU_XOR;   w_imm = {16'h0, w_imm16}; end
                6'h0F: begin w_op = ALU_PASSB; w_imm = {w_imm16, 16'h0}; end
                default: w_op = ALU_NOP;
            endcase
        end
    end

    // r0 writes are dropped at decode so nothing downstream ever targets r0
    assign w_wen = (w_op != ALU_NOP) && (w_dst != 5'd0);

    assign w_rs_val = (w_rs == 5'd0) ? 32'h0 :
                      (r_memwb_wen && (r_memwb_dst == w_rs)) ? r_memwb_result : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? 32'h0 :
                      (r_memwb_wen && (r_memwb_dst == w_rt)) ? r_memwb_result : r_regs[w_rt];

`ifdef SIMPLE_PIPELINE_FORWARDING_EN
    always_comb begin
        w_op_a   = r_idex_rs_val;
        w_rt_fwd = r_idex_rt_val;
        if (r_exmem_wen && (r_exmem_dst != 5'd0) && (r_exmem_dst == r_idex_rs))
            w_op_a = r_exmem_result;
        else if (r_memwb_wen && (r_memwb_dst != 5'd0) && (r_memwb_dst == r_idex_rs))
            w_op_a = r_memwb_result;
        if (r_exmem_wen && (r_exmem_dst != 5'd0) && (r_exmem_dst == r_idex_rt))
            w_rt_fwd = r_exmem_result;
        else if (r_memwb_wen && (r_memwb_dst != 5'd0) && (r_memwb_dst == r_idex_rt))
            w_rt_fwd = r_memwb_result;
    end
`else
    assign w_op_a   = r_idex_rs_val;
    assign w_rt_fwd = r_idex_rt_val;
`endif

    assign w_op_b = r_idex_use_imm ? r_idex_imm : w_rt_fwd;

    always_comb begin
        w_alu_result = 32'h0;
        case (r_idex_op)
            ALU_ADD:   w_alu_result = w_op_a + w_op_b;
            ALU_SUB:   w_alu_result = w_op_a - w_op_b;
            ALU_AND:   w_alu_result = w_op_a & w_op_b;
            ALU_OR:    w_alu_result = w_op_a | w_op_b;
            ALU_XOR:   w_alu_result = w_op_a ^ w_op_b;
            ALU_SLT:   w_alu_result = {31'h0, $signed(w_op_a) < $signed(w_op_b)};
            ALU_SLTU:  w_alu_result = {31'h0, w_op_a < w_op_b};
            ALU_PASSB: w_alu_result = w_op_b;
            default:   w_alu_result = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ifid_instr   <= 32'h0;
            r_idex_op      <= ALU_NOP;
            r_idex_rs_val  <= 32'h0;
            r_idex_rt_val  <= 32'h0;
            r_idex_imm     <= 32'h0;
            r_idex_use_imm <= 1'b0;
            r_idex_wen     <= 1'b0;
            r_idex_dst     <= 5'd0;
`ifdef SIMPLE_PIPELINE_FORWARDING_EN
            r_idex_rs      <= 5'd0;
            r_idex_rt      <= 5'd0;
`endif
            r_exmem_result <= 32'h0;
            r_exmem_wen    <= 1'b0;
            r_exmem_dst    <= 5'd0;
            r_memwb_result <= 32'h0;
            r_memwb_wen    <= 1'b0;
            r_memwb_dst    <= 5'd0;
        end else begin
            r_ifid_instr   <= instruction_in;
            r_idex_op      <= w_op;
            r_idex_rs_val  <= w_rs_val;
            r_idex_rt_val  <= w_rt_val;
            r_idex_imm     <= w_imm;
            r_idex_use_imm <= w_use_imm;
            r_idex_wen     <= w_wen;
            r_idex_dst     <= w_dst;
`ifdef SIMPLE_PIPELINE_FORWARDING_EN
            r_idex_rs      <= w_rs;
            r_idex_rt      <= w_rt;
`endif
            r_exmem_result <= w_alu_result;
            r_exmem_wen    <= r_idex_wen;
            r_exmem_dst    <= r_idex_dst;
            r_memwb_result <= r_exmem_result;
            r_memwb_wen    <= r_exmem_wen;
            r_memwb_dst    <= r_exmem_dst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= 32'h0;
        end else if (r_memwb_wen) begin
            r_regs[r_memwb_dst] <= r_memwb_result;
        end
    end

    assign result_out = r_memwb_result;

endmodule

// File: tb/tb_simple_pipeline.sv
// tb_simple_pipeline: directed and random instruction streams against an in-order ISA model
// whose register visibility lag depends on SIMPLE_PIPELINE_FORWARDING_EN.
module tb_simple_pipeline;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instruction_in = 32'h0;
    logic [31:0] result_out;

    simple_pipeline dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_in (instruction_in),
        .result_out     (result_out)
    );

    always #5 clk = ~clk;

`ifdef SIMPLE_PIPELINE_FORWARDING_EN
    localparam int LAG = 1;
    localparam bit FWD = 1'b1;
`else
    localparam int LAG = 3;
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        bit          wen;
        logic [4:0]  dst;
        logic [31:0] val;
    } wr_t;

    logic [31:0] m_regs [32];
    wr_t         pend_q [$];
    logic [31:0] exp_q  [$];
    string       tag_q  [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // An instruction sees only the writes of instructions issued LAG or more slots earlier.
    task automatic model_exec(input logic [31:0] instr, output logic [31:0] res);
        wr_t         e;
        logic [31:0] a, b, sx, zx;
        logic [5:0]  op, fn;
        logic [4:0]  dst;
        bit          ok;
        while (pend_q.size() >= LAG) begin
            e = pend_q.pop_front();
            if (e.wen) m_regs[e.dst] = e.val;
        end
        op  = instr[31:26];
        fn  = instr[5:0];
        a   = m_regs[instr[25:21]];
        b   = m_regs[instr[20:16]];
        sx  = {{16{instr[15]}}, instr[15:0]};
        zx  = {16'h0, instr[15:0]};
        ok  = 1'b1;
        res = 32'h0;
        dst = instr[20:16];
        if (op == 6'h00) begin
            dst = instr[15:11];
            case (fn)
                6'h21: res = a + b;
                6'h23: res = a - b;
                6'h24: res = a & b;
                6'h25: res = a | b;
                6'h26: res = a ^ b;
                6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                6'h2B: res = (a < b) ? 32'd1 : 32'd0;
                default: ok = 1'b0;
            endcase
        end else begin
            case (op)
                6'h09: res = a + sx;
                6'h0A: res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
                6'h0C: res = a & zx;
                6'h0D: res = a | zx;
                6'h0E: res = a ^ zx;
                6'h0F: res = {instr[15:0], 16'h0};
                default: ok = 1'b0;
            endcase
        end
        if (!ok) res = 32'h0;
        e.wen = ok && (dst != 5'd0);
        e.dst = dst;
        e.val = res;
        pend_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] instr, input bit use_exp,
                         input logic [31:0] exp_val, input string tag);
        logic [31:0] m;
        @(negedge clk);
        if (exp_q.size() >= 4) chk_eq(tag_q.pop_front(), result_out, exp_q.pop_front());
        instruction_in = instr;
        model_exec(instr, m);
        exp_q.push_back(use_exp ? exp_val : m);
        tag_q.push_back(tag);
    endtask

    task automatic issue_m(input logic [31:0] instr);
        issue(instr, 1'b0, 32'h0, "model");
    endtask

    task automatic issue_x(input logic [31:0] instr, input logic [31:0] exp_val, input string tag);
        issue(instr, 1'b1, exp_val, tag);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue_m(32'h0);
    endtask

    task automatic start_reset();
        reset = 1'b1;
        instruction_in = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_eq("rst_hold", result_out, 32'h0);
            instruction_in = $urandom;
        end
        @(negedge clk);
        reset = 1'b0;
        instruction_in = 32'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        pend_q.delete();
        exp_q.delete();
        tag_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            tag_q.push_back("post_rst");
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int          sel;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [5:0]  op, fn;
        sel = $urandom_range(0, 13);
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        imm = 16'($urandom);
        op  = 6'h00;
        fn  = 6'h00;
        case (sel)
            0:  fn = 6'h21;
            1:  fn = 6'h23;
            2:  fn = 6'h24;
            3:  fn = 6'h25;
            4:  fn = 6'h26;
            5:  fn = 6'h2A;
            6:  fn = 6'h2B;
            7:  op = 6'h09;
            8:  op = 6'h0A;
            9:  op = 6'h0C;
            10: op = 6'h0D;
            11: op = 6'h0E;
            12: op = 6'h0F;
            default: begin op = 6'($urandom); fn = 6'($urandom); end
        endcase
        if (op == 6'h00) return {6'h00, rs, rt, rd, 5'h00, fn};
        return {op, rs, rt, imm};
    endfunction

    initial begin
        #1;
        chk_eq("rst_init", result_out, 32'h0);
        start_reset();

        issue_x(32'h24050000, 32'h0, "addiu_zero");
        issue_x(32'h24010005, 32'h5, "addiu_5");
        nops(3);
        issue_x(32'h2422FFFF, 32'h4, "addiu_m1");

        start_reset();
        issue_x(32'h24010007, 32'h7, "b2b_prod");
        issue_x(32'h00211821, FWD ? 32'd14 : 32'd0, "b2b_cons");
        issue_x(32'h24020003, 32'h3, "gap1_prod");
        nops(1);
        issue_x(32'h00422021, FWD ? 32'd6 : 32'd0, "gap1_cons");
        issue_x(32'h24050001, 32'h1, "prio_old");
        issue_x(32'h24050002, 32'h2, "prio_new");
        issue_x(32'h00A53021, FWD ? 32'd4 : 32'd0, "prio_cons");
        nops(3);

        issue_m(32'h24000009);
        issue_x(32'h00002025, 32'h0, "r0_read");
        issue_x(32'h240A0055, 32'h55, "set_r10");
        nops(3);
        issue_x(32'hFC0A1234, 32'h0, "bad_opcode");
        nops(3);
        issue_x(32'h01405825, 32'h55, "no_write");
        issue_x(32'h0140583F, 32'h0, "bad_funct");
        nops(3);

        issue_x(32'h3C061234, 32'h12340000, "lui");
        nops(3);
        issue_x(32'h34C6ABCD, 32'h1234ABCD, "ori");
        nops(3);
        issue_x(32'h28C7FFFF, 32'h0, "slti");

        for (int i = 0; i < 400; i++) issue_m(rand_instr());

        issue_m(32'h24010077);
        nops(3);
        @(negedge clk);
        chk_eq("pre_rst", result_out, 32'h77);
        #2;
        reset = 1'b1;
        #1;
        chk_eq("rst_async", result_out, 32'h0);
        start_reset();
        issue_x(32'h00204025, 32'h0, "rst_discard");

        for (int i = 0; i < 200; i++) issue_m(rand_instr());
        nops(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
